rv_mem_responder: RTL and testbench

Memory-side responder for the pipelined RISC-V core. It serves the core's instruction fetch port and data port as word-organised synchronous BRAM with exactly one cycle of read latency, which is the latency the core's fetch alignment and load stall logic are built around. It also reports sticky misaligned-access and out-of-range error flags. An optional memory-mapped host block can be compiled in; it adds a tohost/halt register and a free-running cycle counter.

---
 rtl/rv_mem_responder_if.sv | 27 ++
 rtl/rv_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_rv_mem_responder.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_mem_responder_if.sv
// rv_mem_responder_if: core <-> memory responder bus.
// Carries the fetch port, the data port, the sticky error flags and the
// optional host (tohost/halt) outputs. clk and rst stay outside the bundle.
interface rv_mem_responder_if;
  logic [31:0] i_addr;
  logic [31:0] i_instr;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        err_misalign;
  logic        err_range;
  logic        halt;
  logic [31:0] tohost;

  // Core side: drives addresses and write data, receives read data and status.
  modport master (
    output i_addr, d_addr, d_we, d_wdata,
    input  i_instr, d_rdata, err_misalign, err_range, halt, tohost
  );

  // Memory side: the responder.
  modport slave (
    input  i_addr, d_addr, d_we, d_wdata,
    output i_instr, d_rdata, err_misalign, err_range, halt, tohost
  );
endinterface

// File: rtl/rv_mem_responder.sv
// rv_mem_responder: word-organised instruction and data BRAM with exactly
// one cycle of read latency on both ports, write-first data port, and sticky
// misaligned / out-of-range error flags.
// Optional host block, enabled by defining RV_MEM_MMIO_EN: tohost register at
// 0xFFFF_FFF0 (a nonzero write sets halt) and a free-running cycle counter at
// 0xFFFF_FFF4 that freezes once halt is set.
module rv_mem_responder #(
  parameter int    IMEM_DEPTH = 1024,
  parameter int    DMEM_DEPTH = 1024,
  parameter string IMEM_INIT  = "imem.hex",
  parameter string DMEM_INIT  = ""
) (
  input  logic                clk,
  input  logic                rst,
  rv_mem_responder_if.slave   bus
);

  localparam int          IAW = $clog2(IMEM_DEPTH);
  localparam int          DAW = $clog2(DMEM_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IDEPTH = 32'(IMEM_DEPTH);
  localparam logic [31:0] DDEPTH = 32'(DMEM_DEPTH);

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];

  // Memories start at all zeros.
  initial begin
    for (int k = 0; k < IMEM_DEPTH; k++) imem[k] = '0;
    for (int k = 0; k < DMEM_DEPTH; k++) dmem[k] = '0;
  end

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [29:0]    i_idx;
  logic [29:0]    d_idx;
  logic           i_in_range;
  logic           d_in_range;
  logic           d_mmio;
  logic           misalign_hit;
  logic           range_hit;
  logic [IAW-1:0] i_waddr;
  logic [DAW-1:0] d_waddr;

  assign i_idx   = bus.i_addr[31:2];
  assign d_idx   = bus.d_addr[31:2];
  assign i_waddr = i_idx[IAW-1:0];
  assign d_waddr = d_idx[DAW-1:0];

  // Full-index compare: upper address bits must not alias into the array.
  assign i_in_range = {2'b00, i_idx} < IDEPTH;
  assign d_in_range = {2'b00, d_idx} < DDEPTH;

`ifdef RV_MEM_MMIO_EN
  localparam logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0;
  localparam logic [31:0] CYCLE_ADDR  = 32'hFFFF_FFF4;

  logic        d_is_tohost;
  logic        d_is_cycle;
  logic [31:0] tohost_q;
  logic        halt_q;
  logic [31:0] cycle_count;

  assign d_is_tohost = bus.d_addr == TOHOST_ADDR;
  assign d_is_cycle  = bus.d_addr == CYCLE_ADDR;
  assign d_mmio      = d_is_tohost | d_is_cycle;
`else
  assign d_mmio = 1'b0;
`endif

  assign misalign_hit = (bus.i_addr[1:0] != 2'b00) | (bus.d_addr[1:0] != 2'b00);
  assign range_hit    = !i_in_range | (!d_in_range & !d_mmio);

  // ---------------------------------------------------------------------------
  // Instruction port
  // ---------------------------------------------------------------------------
  logic [31:0] i_instr_q;

  // Registered fetch: out-of-range fetches return a NOP.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      i_instr_q <= NOP;
    end else begin
      i_instr_q <= i_in_range ? imem[i_waddr] : NOP;
    end
  end

  // ---------------------------------------------------------------------------
  // Data port
  // ---------------------------------------------------------------------------
  logic [31:0] d_rdata_q;
  logic        d_write;

  assign d_write = bus.d_we & d_in_range & !d_mmio & !rst;

  // Data array write; contents survive reset.
  always_ff @(posedge clk) begin
    // NOTE: the memory array has no reset branch; a reset loop over every word
    // would prevent BRAM inference, and reset must not disturb contents anyway.
    if (d_write) begin
      dmem[d_waddr] <= bus.d_wdata;
    end
  end

  // Registered data read, write-first on a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_rdata_q <= '0;
`ifdef RV_MEM_MMIO_EN
    end else if (d_is_tohost) begin
      d_rdata_q <= bus.d_we ? bus.d_wdata : tohost_q;
    end else if (d_is_cycle) begin
      d_rdata_q <= cycle_count;
`endif
    end else if (d_in_range) begin
      d_rdata_q <= bus.d_we ? bus.d_wdata : dmem[d_waddr];
    end else begin
      d_rdata_q <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  logic err_misalign_q;
  logic err_range_q;

  // Flags set the edge after the offending access and hold until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_misalign_q <= 1'b0;
      err_range_q    <= 1'b0;
    end else begin
      err_misalign_q <= err_misalign_q | misalign_hit;
      err_range_q    <= err_range_q | range_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Host block
  // ---------------------------------------------------------------------------
`ifdef RV_MEM_MMIO_EN
  // tohost/halt register and a cycle counter that stops once halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      tohost_q    <= '0;
      halt_q      <= 1'b0;
      cycle_count <= '0;
    end else begin
      if (!halt_q) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (bus.d_we && d_is_tohost) begin
        tohost_q <= bus.d_wdata;
        if (bus.d_wdata != 32'd0) begin
          halt_q <= 1'b1;
        end
      end
    end
  end

  assign bus.halt   = halt_q;
  assign bus.tohost = tohost_q;
`else
  assign bus.halt   = 1'b0;
  assign bus.tohost = '0;
`endif

  assign bus.i_instr      = i_instr_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.err_misalign = err_misalign_q;
  assign bus.err_range    = err_range_q;

endmodule

// File: tb/tb_rv_mem_responder.sv
// tb_rv_mem_responder: directed self-checking bench for rv_mem_responder.
// Inputs change on the falling edge; outputs are checked on the next falling
// edge, i.e. one rising edge after the stimulus. Instruction memory is loaded
// with word k = k before the first edge.
module tb_rv_mem_responder;

  localparam int IDEPTH = 16;
  localparam int DDEPTH = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rv_mem_responder_if bus ();

  rv_mem_responder #(
    .IMEM_DEPTH (IDEPTH),
    .DMEM_DEPTH (DDEPTH),
    .IMEM_INIT  (""),
    .DMEM_INIT  ("")
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] ia, input logic [31:0] da,
                       input logic we, input logic [31:0] wd);
    bus.i_addr  = ia;
    bus.d_addr  = da;
    bus.d_we    = we;
    bus.d_wdata = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h4, 32'h0, 1'b0, 32'h0);
    cyc();
    cyc();
    checks++;
    if (bus.i_instr !== 32'h13) begin
      errors++; $display("FAIL reset_i_instr got %h want %h", bus.i_instr, 32'h13);
    end
    checks++;
    if (bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_d_rdata got %h want %h", bus.d_rdata, 32'h0);
    end
    checks++;
    if ({bus.err_misalign, bus.err_range, bus.halt} !== 3'b000 || bus.tohost !== 32'h0) begin
      errors++;
      $display("FAIL reset_flags got mis=%b rng=%b halt=%b tohost=%h want 0 0 0 0",
               bus.err_misalign, bus.err_range, bus.halt, bus.tohost);
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    for (int k = 0; k < 3; k++) begin
      drive(32'(k * 4), 32'h0, 1'b0, 32'h0);
      cyc();
      checks++;
      if (bus.i_instr !== 32'(k)) begin
        errors++; $display("FAIL fetch_%0d got %h want %h", k, bus.i_instr, 32'(k));
      end
    end
  endtask

  task automatic test_data();
    drive(32'h0, 32'h40, 1'b1, 32'hDEAD_BEEF);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_first got %h want %h", bus.d_rdata, 32'hDEAD_BEEF);
    end
    drive(32'h0, 32'h40, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL read_back got %h want %h", bus.d_rdata, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_back_to_back();
    // Concurrent fetch and write, then read while fetching elsewhere.
    drive(32'hC, 32'h44, 1'b1, 32'h0000_0011);
    cyc();
    checks++;
    if (bus.i_instr !== 32'h3 || bus.d_rdata !== 32'h11) begin
      errors++; $display("FAIL concurrent_wr got i=%h d=%h want i=%h d=%h",
                         bus.i_instr, bus.d_rdata, 32'h3, 32'h11);
    end
    drive(32'h14, 32'h44, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.i_instr !== 32'h5 || bus.d_rdata !== 32'h11) begin
      errors++; $display("FAIL concurrent_rd got i=%h d=%h want i=%h d=%h",
                         bus.i_instr, bus.d_rdata, 32'h5, 32'h11);
    end
    checks++;
    if (bus.err_misalign !== 1'b0 || bus.err_range !== 1'b0) begin
      errors++; $display("FAIL flags_clean got mis=%b rng=%b want 0 0",
                         bus.err_misalign, bus.err_range);
    end
  endtask

  task automatic test_errors();
    drive(32'h0, 32'h42, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.err_misalign !== 1'b1 || bus.err_range !== 1'b0 || bus.d_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL misalign got mis=%b rng=%b d=%h want 1 0 %h",
                         bus.err_misalign, bus.err_range, bus.d_rdata, 32'hDEAD_BEEF);
    end
    drive(32'h0, 32'(DDEPTH * 4), 1'b1, 32'h5555_5555);
    cyc();
    checks++;
    if (bus.err_range !== 1'b1 || bus.d_rdata !== 32'h0 || bus.err_misalign !== 1'b1) begin
      errors++; $display("FAIL range_write got rng=%b mis=%b d=%h want 1 1 0",
                         bus.err_range, bus.err_misalign, bus.d_rdata);
    end
    // A truncated index would have aliased that write onto word 0.
    drive(32'h0, 32'h0, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL range_no_alias got %h want %h", bus.d_rdata, 32'h0);
    end
    // High address bits set: must not alias onto word 0x40.
    drive(32'h0, 32'h8000_0040, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL range_full_index got %h want %h", bus.d_rdata, 32'h0);
    end
    drive(32'(IDEPTH * 4), 32'h0, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.i_instr !== 32'h13) begin
      errors++; $display("FAIL fetch_range got %h want %h", bus.i_instr, 32'h13);
    end
    drive(32'h0, 32'h0, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.err_misalign !== 1'b1 || bus.err_range !== 1'b1) begin
      errors++; $display("FAIL flags_sticky got mis=%b rng=%b want 1 1",
                         bus.err_misalign, bus.err_range);
    end
  endtask

  task automatic test_reset_mid_write();
    drive(32'h0, 32'h80, 1'b1, 32'h0000_CAFE);
    cyc();
    rst = 1'b1;
    drive(32'h8, 32'h80, 1'b1, 32'h0000_1234);
    cyc();
    checks++;
    if (bus.i_instr !== 32'h13 || bus.d_rdata !== 32'h0 ||
        bus.err_misalign !== 1'b0 || bus.err_range !== 1'b0) begin
      errors++; $display("FAIL reset_mid got i=%h d=%h mis=%b rng=%b want 13 0 0 0",
                         bus.i_instr, bus.d_rdata, bus.err_misalign, bus.err_range);
    end
    rst = 1'b0;
    drive(32'h8, 32'h80, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'h0000_CAFE || bus.i_instr !== 32'h2) begin
      errors++; $display("FAIL reset_no_write got d=%h i=%h want d=%h i=%h",
                         bus.d_rdata, bus.i_instr, 32'h0000_CAFE, 32'h2);
    end
  endtask

`ifdef RV_MEM_MMIO_EN
  task automatic test_counter_wrap();
    logic [31:0] first;
    drive(32'h0, 32'hFFFF_FFF4, 1'b0, 32'h0);
    force dut.cycle_count = 32'hFFFF_FFFE;
    cyc();
    release dut.cycle_count;
    cyc();  // reads FFFF_FFFE, counter -> FFFF_FFFF
    cyc();  // reads FFFF_FFFF, counter -> 0
    checks++;
    if (bus.d_rdata !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL count_max got %h want %h", bus.d_rdata, 32'hFFFF_FFFF);
    end
    cyc();  // reads 0
    checks++;
    if (bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL count_wrap got %h want %h", bus.d_rdata, 32'h0);
    end
    first = bus.d_rdata;
    cyc();
    checks++;
    if (bus.d_rdata !== first + 32'd1) begin
      errors++; $display("FAIL count_inc got %h want %h", bus.d_rdata, first + 32'd1);
    end
  endtask

  task automatic test_mmio();
    logic [31:0] first;
    drive(32'h0, 32'hFFFF_FFF0, 1'b1, 32'h0);
    cyc();
    checks++;
    if (bus.halt !== 1'b0 || bus.tohost !== 32'h0) begin
      errors++; $display("FAIL mmio_zero got halt=%b tohost=%h want 0 0", bus.halt, bus.tohost);
    end
    drive(32'h0, 32'hFFFF_FFF0, 1'b1, 32'h1);
    cyc();
    checks++;
    if (bus.halt !== 1'b1 || bus.tohost !== 32'h1) begin
      errors++; $display("FAIL mmio_halt got halt=%b tohost=%h want 1 1", bus.halt, bus.tohost);
    end
    drive(32'h0, 32'hFFFF_FFF0, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'h1) begin
      errors++; $display("FAIL mmio_tohost_rd got %h want %h", bus.d_rdata, 32'h1);
    end
    drive(32'h0, 32'hFFFF_FFF4, 1'b0, 32'h0);
    cyc();
    first = bus.d_rdata;
    for (int k = 0; k < 3; k++) begin
      cyc();
      checks++;
      if (bus.d_rdata !== first) begin
        errors++; $display("FAIL mmio_frozen_%0d got %h want %h", k, bus.d_rdata, first);
      end
    end
    checks++;
    if (bus.err_range !== 1'b0 || bus.err_misalign !== 1'b0) begin
      errors++; $display("FAIL mmio_no_err got rng=%b mis=%b want 0 0",
                         bus.err_range, bus.err_misalign);
    end
  endtask
`else
  task automatic test_mmio();
    drive(32'h0, 32'hFFFF_FFF0, 1'b1, 32'h0);
    cyc();
    drive(32'h0, 32'hFFFF_FFF0, 1'b1, 32'h1);
    cyc();
    checks++;
    if (bus.err_range !== 1'b1 || bus.halt !== 1'b0 || bus.tohost !== 32'h0 ||
        bus.d_rdata !== 32'h0) begin
      errors++; $display("FAIL nommio_write got rng=%b halt=%b tohost=%h d=%h want 1 0 0 0",
                         bus.err_range, bus.halt, bus.tohost, bus.d_rdata);
    end
    drive(32'h0, 32'hFFFF_FFF4, 1'b0, 32'h0);
    cyc();
    checks++;
    if (bus.d_rdata !== 32'h0 || bus.err_misalign !== 1'b0) begin
      errors++; $display("FAIL nommio_read got d=%h mis=%b want 0 0",
                         bus.d_rdata, bus.err_misalign);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    for (int k = 0; k < IDEPTH; k++) dut.imem[k] = 32'(k);
    test_reset();
    test_fetch();
    test_data();
    test_back_to_back();
    test_errors();
    test_reset_mid_write();
`ifdef RV_MEM_MMIO_EN
    test_counter_wrap();
`endif
    test_mmio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
